// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB transmit bit sequencer.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_seq_state_t;

  localparam logic [7:0] USB_SYNC_BYTE    = 8'h80;
  localparam int         USB_EOP_SE0_BITS = 2;

endpackage

// File: rtl/usb_tx_shifter.sv
// 8-bit LSB-first shift register with bit index; load takes priority over consume.
module usb_tx_shifter (
  input  logic       clk,
  input  logic       nRST,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       consume,
  output logic       bit_out,
  output logic       last_bit
);

  logic [7:0] shift;
  logic [2:0] idx;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      shift <= '0;
      idx   <= '0;
    end else if (load) begin
      shift <= load_data;
      idx   <= '0;
    end else if (consume) begin
      shift <= {1'b0, shift[7:1]};
      idx   <= idx + 3'd1;
    end
  end

  assign bit_out  = shift[0];
  assign last_bit = (idx == 3'd7);

endmodule

// File: rtl/usb_tx_bit_sequencer.sv
// Frames packet bytes as SYNC, payload (LSB first), EOP and feeds the bit stuffer
// one bit per bit_tick, re-presenting a bit whenever the stuffer takes a stuff slot.
module usb_tx_bit_sequencer
  import usb_tx_pkg::*;
#(
  parameter logic [7:0] SYNC_PATTERN = USB_SYNC_BYTE,
  parameter int         EOP_SE0_BITS = USB_EOP_SE0_BITS
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       bit_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       stf_bit,
  output logic       stf_en,
  input  logic       stf_valid,
  output logic       tx_se0,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [2:0] EOP_LAST = 3'(EOP_SE0_BITS - 1);

  tx_seq_state_t state, state_next;

  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_full;
  logic       cur_last;
  logic [2:0] eop_cnt, eop_cnt_next;

  logic       accept;
  logic       consume;
  logic       last_bit;
  logic       sh_load;
  logic [7:0] sh_data;
  logic       unload;
  logic       done_next;
  logic       under_next;

  assign tx_ready  = !hold_full;
  assign accept    = tx_valid && !hold_full;
  assign stf_en    = bit_tick && ((state == ST_SYNC) || (state == ST_DATA));
  assign consume   = stf_en && stf_valid;
  assign tx_se0    = (state == ST_EOP_SE0);
  assign tx_active = (state != ST_IDLE);

  usb_tx_shifter u_shifter (
    .clk       (clk),
    .nRST      (nRST),
    .load      (sh_load),
    .load_data (sh_data),
    .consume   (consume),
    .bit_out   (stf_bit),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_next   = state;
    eop_cnt_next = eop_cnt;
    sh_load      = 1'b0;
    sh_data      = hold_data;
    unload       = 1'b0;
    done_next    = 1'b0;
    under_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full || accept) begin
          state_next = ST_SYNC;
          sh_load    = 1'b1;
          sh_data    = SYNC_PATTERN;
        end
      end
      ST_SYNC: begin
        if (consume && last_bit) begin
          state_next = ST_DATA;
          sh_load    = 1'b1;
          unload     = 1'b1;
        end
      end
      ST_DATA: begin
        if (consume && last_bit) begin
          if (cur_last) begin
            state_next = ST_EOP_SE0;
          end else if (hold_full) begin
            sh_load = 1'b1;
            unload  = 1'b1;
          end else begin
            // Starved mid-packet: abort straight into EOP.
            under_next = 1'b1;
            state_next = ST_EOP_SE0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_tick) begin
          if (eop_cnt == EOP_LAST) begin
            state_next   = ST_EOP_J;
            eop_cnt_next = '0;
          end else begin
            eop_cnt_next = eop_cnt + 3'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_tick) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      eop_cnt     <= '0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_next;
      eop_cnt     <= eop_cnt_next;
      tx_done     <= done_next;
      tx_underrun <= under_next;
    end
  end

  // Holding register: refilled only while empty, so accept and unload never collide.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      hold_data <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      cur_last  <= 1'b0;
    end else begin
      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end else if (unload) begin
        hold_full <= 1'b0;
      end
      if (unload) begin
        cur_last <= hold_last;
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_sequencer.sv
// Scoreboard bench: expected line events are queued by the stimulus, a monitor pops and compares.
module tb_usb_tx_bit_sequencer;

  localparam int EV_B0 = 0, EV_B1 = 1, EV_ST0 = 2, EV_ST1 = 3,
                 EV_SE0 = 4, EV_J = 5, EV_DONE = 6, EV_UNDER = 7;

  logic       clk = 1'b0;
  logic       nRST;
  logic       bit_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       stf_bit;
  logic       stf_en;
  logic       stf_valid;
  logic       tx_se0;
  logic       tx_active;
  logic       tx_done;
  logic       tx_underrun;

  int n_cmp = 0;
  int n_fail = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int stall_at = -1;
  int exp_q[$];

  usb_tx_bit_sequencer dut (
    .clk         (clk),
    .nRST        (nRST),
    .bit_tick    (bit_tick),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .stf_bit     (stf_bit),
    .stf_en      (stf_en),
    .stf_valid   (stf_valid),
    .tx_se0      (tx_se0),
    .tx_active   (tx_active),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  // Bit-time strobe every 4 clocks; stf_valid dropped on the chosen presentation tick.
  initial begin
    bit_tick  = 1'b0;
    stf_valid = 1'b1;
    forever begin
      repeat (3) @(posedge clk);
      #1;
      stf_valid = (en_cnt != stall_at);
      bit_tick  = 1'b1;
      @(posedge clk);
      #1;
      bit_tick  = 1'b0;
      stf_valid = 1'b1;
    end
  end

  task automatic check_ev(input int got);
    int e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL line_event: got %0d, expected none", got);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        n_fail++;
        $display("FAIL line_event: got %0d, expected %0d", got, e);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (tx_underrun) check_ev(EV_UNDER);
      if (tx_done) begin
        check_ev(EV_DONE);
        done_cnt++;
      end
      if (bit_tick) begin
        if (stf_en) begin
          check_ev(stf_valid ? int'(stf_bit) : 2 + int'(stf_bit));
          en_cnt++;
        end else if (tx_se0) begin
          check_ev(EV_SE0);
        end else if (tx_active) begin
          check_ev(EV_J);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) exp_q.push_back(int'(b[i]));
  endtask

  task automatic push_eop();
    exp_q.push_back(EV_SE0);
    exp_q.push_back(EV_SE0);
    exp_q.push_back(EV_J);
    exp_q.push_back(EV_DONE);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    if (i == 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tx_ready_wait: got 0, expected 1 within 300 cycles");
    end else begin
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 2000 && done_cnt < target; i++) @(posedge clk);
    check("tx_done_seen", done_cnt, target);
    @(negedge clk);
    check("tx_active_after_done", int'(tx_active), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int dbase;
    nRST     = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    #1;
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_stf_bit", int'(stf_bit), 0);
    check("rst_stf_en", int'(stf_en), 0);
    check("rst_tx_se0", int'(tx_se0), 0);
    check("rst_tx_active", int'(tx_active), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_tx_underrun", int'(tx_underrun), 0);
    repeat (3) @(negedge clk);
    nRST = 1'b1;

    // Idle for 20 ticks: no presentation strobes
    base = en_cnt;
    repeat (80) @(posedge clk);
    check("idle_no_stf_en", en_cnt, base);
    check("idle_tx_ready", int'(tx_ready), 1);

    // Single byte A5 with last
    push_byte(8'h80);
    push_byte(8'hA5);
    push_eop();
    send_byte(8'hA5, 1'b1);
    check("active_after_accept", int'(tx_active), 1);
    check("ready_low_when_full", int'(tx_ready), 0);
    wait_done(1);

    // Byte FF with a stuff slot on the 7th payload tick
    base = en_cnt;
    stall_at = base + 14;
    push_byte(8'h80);
    for (int i = 0; i < 6; i++) exp_q.push_back(EV_B1);
    exp_q.push_back(EV_ST1);
    exp_q.push_back(EV_B1);
    exp_q.push_back(EV_B1);
    push_eop();
    send_byte(8'hFF, 1'b1);
    wait_done(2);
    check("stuff_tick_count", en_cnt - base, 17);
    stall_at = -1;

    // Three back-to-back bytes
    base = en_cnt;
    push_byte(8'h80);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_eop();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    wait_done(3);
    check("three_byte_ticks", en_cnt - base, 32);

    // Second byte withheld: underrun abort
    push_byte(8'h80);
    push_byte(8'h3C);
    exp_q.push_back(EV_UNDER);
    push_eop();
    send_byte(8'h3C, 1'b0);
    wait_done(4);

    // Reset while DATA bit 3 is presented
    base = en_cnt;
    dbase = done_cnt;
    push_byte(8'h80);
    push_byte(8'h5A);
    send_byte(8'h5A, 1'b1);
    for (int i = 0; i < 500 && en_cnt < base + 11; i++) @(posedge clk);
    check("reached_data_bit3", en_cnt - base, 11);
    #2;
    nRST = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_tx_ready", int'(tx_ready), 1);
    check("midrst_stf_bit", int'(stf_bit), 0);
    check("midrst_tx_active", int'(tx_active), 0);
    check("midrst_tx_se0", int'(tx_se0), 0);
    @(negedge clk);
    nRST = 1'b1;
    repeat (40) @(posedge clk);
    check("midrst_no_eop", done_cnt, dbase);

    push_byte(8'h80);
    push_byte(8'hC3);
    push_eop();
    send_byte(8'hC3, 1'b1);
    wait_done(dbase + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_tx_bit_sequencer.md
# usb_tx_bit_sequencer

Transmit-side controller that serialises USB packet bytes into the bit-stuffing stage, one bit per bit-time strobe. It frames each packet as SYNC, then payload (LSB first), then EOP. It re-presents a bit whenever the stuffer inserts a stuff slot. It sits between the packet/CRC layer (byte handshake) and the bit stuffer / NRZI encoder (bit strobe interface).

## Interface
- SYNC_PATTERN, 8'h80, SYNC byte, sent LSB first through the stuffer.
- EOP_SE0_BITS, 2, bit times of SE0 in EOP (1..7).
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- bit_tick  in  1  one-cycle strobe per USB bit time; spacing ≥2 cycles
- tx_data  in  8  payload byte
- tx_valid  in  1  tx_data/tx_last valid
- tx_last  in  1  byte is last of packet
- tx_ready  out  1  byte accepted when tx_valid && tx_ready
- stf_bit  out  1  bit presented to stuffer
- stf_en  out  1  present strobe to stuffer
- stf_valid  in  1  stuffer consumed stf_bit (low = stuff slot, bit not taken)
- tx_se0  out  1  drive SE0 (EOP), bypasses stuffer
- tx_active  out  1  packet on the line (SYNC through EOP J)
- tx_done  out  1  one-cycle pulse at end of EOP
- tx_underrun  out  1  one-cycle pulse when a byte was needed and none was held

## Operation
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- One-byte holding register: hold_data, hold_last, hold_full. tx_ready = !hold_full, registered-based, no same-cycle bypass.
- 8-bit shift register plus 3-bit bit index. stf_bit = shift[0], combinational.
- stf_en = bit_tick && state ∈ {SYNC, DATA}; 0 otherwise.
- A bit is consumed when stf_en && stf_valid:
  - shift right, bit index +1.
  - If stf_valid = 0, shift and index hold. The same bit is re-presented on the next tick.
- IDLE: a byte accept sets hold_full. Next state SYNC; shift ← SYNC_PATTERN, index ← 0.
- SYNC: on consuming bit 7, shift ← hold_data, hold_full ← 0, capture last flag; go to DATA.
- DATA: on consuming bit 7:
  - Current byte is last → EOP_SE0.
  - Else hold_full → load next byte, stay in DATA.
  - Else → tx_underrun pulse, EOP_SE0 (abort).
- Simultaneous hold unload and new accept cannot occur (tx_ready low while full).
- EOP_SE0: tx_se0 = 1. Counts bit_ticks; after EOP_SE0_BITS ticks → EOP_J.
- EOP_J: tx_se0 = 0, tx_active = 1. On the next tick → IDLE with a tx_done pulse.
- tx_done pulses after normal and aborted EOPs alike.

## Timing
- Reset values: tx_ready 1, stf_bit 0, stf_en 0, tx_se0 0, tx_active 0, tx_done 0, tx_underrun 0. State IDLE; hold, shift, index and counters cleared.
- Reset asserted mid-packet clears everything immediately (asynchronously). No EOP is generated.
- tx_active rises the cycle after the first byte is accepted. It falls in the cycle tx_done pulses.
- Payload bit latency: a byte accepted while hold is empty appears on stf_bit at the first tick after the preceding byte's bit 7 is consumed. There are no idle ticks between bytes.
- State changes, tx_se0 and pulses are registered, effective the cycle after the triggering tick.
- bit_tick outside SYNC/DATA/EOP states is ignored.
- stf_valid is sampled only when stf_en = 1.

## Structure
- Shared package usb_tx_pkg holds:
  - state enum tx_seq_state_t;
  - USB_SYNC_BYTE = 8'h80;
  - USB_EOP_SE0_BITS = 2, as defaults for the parameters.
- One natural sub-module: usb_tx_shifter. It holds the 8-bit shift register and bit index, with load/consume inputs and a last-bit flag.
- FSM, hold register and EOP counter live in the top.

## Test plan
- Reset → all outputs at reset values, tx_ready = 1, no stf_en for 20 ticks.
- One byte 8'hA5 with tx_last, tick every 4 clocks, stf_valid = 1 → expected response:
  - consumed bits 0,0,0,0,0,0,0,1 then 1,0,1,0,0,1,0,1;
  - tx_se0 high for 2 ticks, then one J tick;
  - tx_done pulses once, then tx_active = 0.
- Byte 8'hFF, stf_valid forced low on the 7th payload tick → bit re-presented (stf_bit = 1) on the next tick. Byte completes after 9 payload ticks. EOP follows normally.
- Three bytes 8'h01, 8'h02, 8'h03 (last) supplied whenever tx_ready → 32 consecutive consumed ticks (SYNC + 24), then SE0. No underrun.
- Two-byte packet with the second byte withheld → tx_underrun pulses once after bit 7 of byte 0. Then 2 SE0 ticks, J, tx_done.
- nRST asserted during DATA bit 3 → outputs return to reset values immediately. The next packet starts with full SYNC 8'h80.
